// File: rtl/frame_serializer.sv
// frame_serializer: captures a FRAME_W-bit frame on load and streams it
// out SYM_W bits per valid/ready transfer, LSB symbol first.
//
// Optional feature macro: SER_PARITY_EN (adds sym_par output).
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         capture frame_in and start a frame (idle only)
//   frame_in     frame vector, symbol k = frame_in[k*SYM_W +: SYM_W]
//   abort        terminate the current frame
//   sym_out      current symbol (0 when not valid)
//   sym_valid    sym_out valid
//   sym_ready    downstream accepts
//   sym_first    symbol 0 is presented
//   sym_last     symbol NUM_SYM-1 is presented
//   sym_par      even parity of sym_out (SER_PARITY_EN only)
//   busy         frame in progress
//   done         pulse after the last symbol transfers
//   overrun      pulse when a load is rejected
module frame_serializer #(
   parameter int FRAME_W    = 5408,
   parameter int SYM_W      = 8,
   parameter int GAP_CYCLES = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [FRAME_W-1:0] frame_in,
   input  logic               abort,
   output logic [SYM_W-1:0]   sym_out,
   output logic               sym_valid,
   input  logic               sym_ready,
   output logic               sym_first,
   output logic               sym_last,
`ifdef SER_PARITY_EN
   output logic               sym_par,
`endif
   output logic               busy,
   output logic               done,
   output logic               overrun
);

   localparam int NUM_SYM = FRAME_W / SYM_W;
   localparam int IDX_W =
      (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
   localparam int GAP_W =
      (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX =
      IDX_W'(NUM_SYM - 1);
   localparam logic [GAP_W-1:0] GAP_LAST =
      GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             done_q, done_d;
   logic             ovr_q, ovr_d;
   logic             cap;
   logic             is_last;

   // Symbol view of the captured frame; the index never exceeds
   // LAST_IDX, so no select past the frame end can occur.
   logic [NUM_SYM-1:0][SYM_W-1:0] shadow_q;

   assign is_last = (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         gap_q    <= '0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         shadow_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         if (cap)
            shadow_q <= frame_in;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
      cap     = 1'b0;

      // Any load outside IDLE is rejected, including one
      // coincident with abort.
      if (load && (state_q != IDLE))
         ovr_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (load) begin
               cap     = 1'b1;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            // abort outranks a same-cycle transfer
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (sym_ready) begin
               if (is_last) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
                  if (GAP_CYCLES > 0) begin
                     state_d = GAP;
                     gap_d   = '0;
                  end
               end
            end
         end
         GAP: begin
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (gap_q == GAP_LAST) begin
               state_d = SEND;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign sym_valid = (state_q == SEND);
   assign sym_out   = sym_valid ? shadow_q[idx_q] : '0;
   assign sym_first = sym_valid && (idx_q == '0);
   assign sym_last  = sym_valid && is_last;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign overrun   = ovr_q;

`ifdef SER_PARITY_EN
   // sym_out is already 0 when not valid, so parity is 0 too.
   assign sym_par = ^sym_out;
`endif

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed bench for
// frame_serializer (gap 0 and gap 2 instances).
module tb_frame_serializer;

  typedef struct packed {
    logic [7:0] s;
    logic       f;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        load0, abort0, rdy0;
  logic [31:0] frame0;
  logic [7:0]  sym0;
  logic        v0, f0, l0;
  logic        busy0, done0, ovr0;

  logic        load2, abort2, rdy2;
  logic [31:0] frame2;
  logic [7:0]  sym2;
  logic        v2, f2, l2;
  logic        busy2, done2, ovr2;

`ifdef SER_PARITY_EN
  logic par0, par2;
`endif

  int checks   = 0;
  int failures = 0;

  exp_t sb[$];
  exp_t mon_e;

  logic [9:0] pat = 10'b1001001001;

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  frame_serializer #(
    .FRAME_W(32), .SYM_W(8), .GAP_CYCLES(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .load(load0), .frame_in(frame0),
    .abort(abort0),
    .sym_out(sym0), .sym_valid(v0),
    .sym_ready(rdy0),
    .sym_first(f0), .sym_last(l0),
`ifdef SER_PARITY_EN
    .sym_par(par0),
`endif
    .busy(busy0), .done(done0),
    .overrun(ovr0)
  );

  frame_serializer #(
    .FRAME_W(32), .SYM_W(8), .GAP_CYCLES(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .load(load2), .frame_in(frame2),
    .abort(abort2),
    .sym_out(sym2), .sym_valid(v2),
    .sym_ready(rdy2),
    .sym_first(f2), .sym_last(l2),
`ifdef SER_PARITY_EN
    .sym_par(par2),
`endif
    .busy(busy2), .done(done2),
    .overrun(ovr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(
    input logic [31:0] f
  );
    for (int k = 0; k < 4; k++)
      sb.push_back('{f[k*8 +: 8],
                     (k == 0), (k == 3)});
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done0 && n < max) begin
      tick();
      n++;
    end
    chk("done_seen", done0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && v0 && rdy0 && !abort0) begin
      chk("sb_avail", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sym", {sym0, f0, l0},
            {mon_e.s, mon_e.f, mon_e.l});
`ifdef SER_PARITY_EN
        chk("par", par0, ^mon_e.s);
`endif
      end
    end
  end

  initial begin
    int k;
    rst_n  = 1'b0;
    load0  = 1'b0;
    abort0 = 1'b0;
    rdy0   = 1'b1;
    frame0 = '0;
    load2  = 1'b0;
    abort2 = 1'b0;
    rdy2   = 1'b1;
    frame2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_u0", {v0, f0, l0, busy0,
        done0, ovr0, sym0}, 14'h0);
    chk("rst_u2", {v2, f2, l2, busy2,
        done2, ovr2, sym2}, 14'h0);
    rst_n = 1'b1;
    tick();

    frame0 = 32'hDDCCBBAA;
    load0  = 1'b1;
    push_frame(frame0);
    tick();
    load0 = 1'b0;
    chk("t1_first", {v0, f0, sym0},
        {1'b1, 1'b1, 8'hAA});
    for (int i = 0; i < 4; i++) begin
      chk("t1_busy", {busy0, done0}, 2'b10);
      tick();
    end
    chk("t1_done", {busy0, done0}, 2'b01);
    tick();
    chk("t1_done_pulse", done0, 1'b0);

    load0 = 1'b1;
    push_frame(frame0);
    tick();
    load0 = 1'b0;
    tick();
    rdy0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold", {v0, sym0},
          {1'b1, 8'hBB});
      tick();
    end
    rdy0 = 1'b1;
    chk("t2_hold", {v0, sym0}, {1'b1, 8'hBB});
    wait_done(10);
    tick();

    load0 = 1'b1;
    push_frame(frame0);
    tick();
    load0 = 1'b0;
    tick();
    load0  = 1'b1;
    frame0 = 32'h11223344;
    tick();
    load0 = 1'b0;
    chk("t3_ovr", ovr0, 1'b1);
    chk("t3_keep", sym0, 8'hCC);
    tick();
    chk("t3_ovr_pulse", ovr0, 1'b0);
    wait_done(10);
    load0 = 1'b1;
    push_frame(frame0);
    tick();
    load0 = 1'b0;
    chk("t3_b2b", {v0, f0, sym0},
        {1'b1, 1'b1, 8'h44});
    wait_done(10);
    tick();

    frame0 = 32'hDDCCBBAA;
    load0  = 1'b1;
    push_frame(frame0);
    tick();
    load0 = 1'b0;
    tick();
    tick();
    rdy0 = 1'b0;
    tick();
    chk("t4_wait", sym0, 8'hCC);
    abort0 = 1'b1;
    rdy0   = 1'b1;
    load0  = 1'b1;
    tick();
    abort0 = 1'b0;
    load0  = 1'b0;
    chk("t4_idle", {v0, busy0, f0, l0,
        done0, sym0}, 13'h0);
    chk("t4_ovr", ovr0, 1'b1);
    chk("t4_left", sb.size(), 2);
    sb.delete();
    tick();
    chk("t4_nodone", done0, 1'b0);

    frame0 = 32'h07030100;
    load0  = 1'b1;
    push_frame(frame0);
    tick();
    load0 = 1'b0;
    chk("t4_restart", {f0, sym0},
        {1'b1, 8'h00});
    wait_done(10);
    tick();

    frame0 = 32'hDDCCBBAA;
    load0  = 1'b1;
    push_frame(frame0);
    tick();
    load0 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst", {v0, f0, l0, busy0,
        done0, ovr0, sym0}, 14'h0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    chk("t5_nodone", done0, 1'b0);
    tick();
    load0 = 1'b1;
    push_frame(frame0);
    tick();
    load0 = 1'b0;
    chk("t5_restart", {f0, sym0},
        {1'b1, 8'hAA});
    wait_done(10);
    tick();

    frame2 = 32'hDDCCBBAA;
    load2  = 1'b1;
    tick();
    load2 = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      chk("gap_valid", v2, pat[i]);
      chk("gap_nodone", done2, 1'b0);
      if (pat[i]) begin
        chk("gap_sym", sym2,
            frame2[k*8 +: 8]);
        k++;
      end
      tick();
    end
    chk("gap_done", {done2, busy2}, 2'b10);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
